// File: rtl/usb_pkt_tx.sv
// USB 2.0 full-speed packet transmitter: PID byte, payload and CRC16 toward the UTMI transmit port.
// Handshakes send only the PID; data packets send PID, payload and CRC16; token/special PIDs are rejected.
module usb_pkt_tx #(
  parameter int MAX_PAYLOAD = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pkt_start,
  input  logic [3:0] pkt_pid,
  input  logic       pkt_zlp,
  input  logic [7:0] pkt_data,
  input  logic       pkt_data_valid,
  input  logic       pkt_data_last,
  output logic       pkt_data_ready,
  output logic       pkt_busy,
  output logic       pkt_done,
  output logic       pkt_err,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready
);

  typedef enum logic [2:0] {S_IDLE, S_PID, S_DATA, S_CRC_LO, S_CRC_HI} state_t;

  state_t      state_q, state_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_valid_q, tx_valid_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [15:0] crc_q, crc_d;
  logic [6:0]  cnt_q, cnt_d;
  logic        is_data_q, is_data_d;
  logic        zlp_q, zlp_d;
  logic        last_q, last_d;

  logic accept, take, underrun;

  // Reflected CRC16 (0xA001), one payload byte per call, LSB first.
  function automatic logic [15:0] crc16_upd(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c ^ {8'h00, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
    end
    return r;
  endfunction

  assign accept   = tx_valid_q & tx_ready;
  assign take     = accept & (((state_q == S_PID) & is_data_q & ~zlp_q) |
                              ((state_q == S_DATA) & ~last_q));
  assign underrun = take & ~pkt_data_valid;

  assign pkt_data_ready = take;
  assign pkt_busy       = (state_q != S_IDLE);
  assign pkt_done       = done_q;
  assign pkt_err        = err_q;
  assign tx_data        = tx_data_q;
  assign tx_valid       = tx_valid_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      crc_q      <= 16'hFFFF;
      cnt_q      <= 7'd0;
      is_data_q  <= 1'b0;
      zlp_q      <= 1'b0;
      last_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      done_q     <= done_d;
      err_q      <= err_d;
      crc_q      <= crc_d;
      cnt_q      <= cnt_d;
      is_data_q  <= is_data_d;
      zlp_q      <= zlp_d;
      last_q     <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (pkt_start && pkt_pid[1]) state_d = S_PID;
      S_PID: begin
        if (accept) begin
          if (!is_data_q)    state_d = S_IDLE;
          else if (zlp_q)    state_d = S_CRC_LO;
          else if (underrun) state_d = S_IDLE;
          else               state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (accept) begin
          if (last_q)        state_d = S_CRC_LO;
          else if (underrun) state_d = S_IDLE;
        end
      end
      S_CRC_LO: if (accept) state_d = S_CRC_HI;
      S_CRC_HI: if (accept) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    crc_d      = crc_q;
    cnt_d      = cnt_q;
    is_data_d  = is_data_q;
    zlp_d      = zlp_q;
    last_d     = last_q;
    case (state_q)
      S_IDLE: begin
        if (pkt_start) begin
          crc_d  = 16'hFFFF;
          cnt_d  = 7'd0;
          last_d = 1'b0;
          if (pkt_pid[1]) begin
            tx_valid_d = 1'b1;
            tx_data_d  = {~pkt_pid, pkt_pid};
            is_data_d  = pkt_pid[0];
            zlp_d      = pkt_zlp;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_PID: begin
        if (accept && !is_data_q) begin
          tx_valid_d = 1'b0;
          done_d     = 1'b1;
        end else if (accept && zlp_q) begin
          tx_data_d = ~crc_q[7:0];
        end
      end
      S_DATA:   if (accept && last_q) tx_data_d = ~crc_q[7:0];
      S_CRC_LO: if (accept) tx_data_d = ~crc_q[15:8];
      S_CRC_HI: begin
        if (accept) begin
          tx_valid_d = 1'b0;
          done_d     = 1'b1;
        end
      end
      default: ;
    endcase
    // Payload consumption is shared by the PID (first byte) and DATA states.
    if (take) begin
      if (underrun) begin
        tx_valid_d = 1'b0;
        err_d      = 1'b1;
      end else begin
        tx_data_d = pkt_data;
        crc_d     = crc16_upd(crc_q, pkt_data);
        cnt_d     = (cnt_q == 7'h7F) ? cnt_q : cnt_q + 7'd1;
        last_d    = pkt_data_last | (cnt_q == 7'(MAX_PAYLOAD - 1));
      end
    end
  end

endmodule

// File: tb/tb_usb_pkt_tx.sv
// Directed bench for usb_pkt_tx: handshakes, ZLP, payload with stalls, underrun, rejects, truncation, reset.
module tb_usb_pkt_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       pkt_start, pkt_zlp, pkt_data_valid, pkt_data_last, tx_ready;
  logic [3:0] pkt_pid;
  logic [7:0] pkt_data;
  logic       sel;

  logic       rdy_a, busy_a, done_a, err_a, val_a;
  logic       rdy_b, busy_b, done_b, err_b, val_b;
  logic [7:0] txd_a, txd_b;
  logic       pkt_data_ready, pkt_busy, pkt_done, pkt_err, tx_valid;
  logic [7:0] tx_data;

  always #5 clk = ~clk;

  usb_pkt_tx #(.MAX_PAYLOAD(64)) u_dut (
    .clk(clk), .rst(rst), .pkt_start(pkt_start & ~sel), .pkt_pid(pkt_pid), .pkt_zlp(pkt_zlp),
    .pkt_data(pkt_data), .pkt_data_valid(pkt_data_valid), .pkt_data_last(pkt_data_last),
    .pkt_data_ready(rdy_a), .pkt_busy(busy_a), .pkt_done(done_a), .pkt_err(err_a),
    .tx_data(txd_a), .tx_valid(val_a), .tx_ready(tx_ready));

  usb_pkt_tx #(.MAX_PAYLOAD(4)) u_dut4 (
    .clk(clk), .rst(rst), .pkt_start(pkt_start & sel), .pkt_pid(pkt_pid), .pkt_zlp(pkt_zlp),
    .pkt_data(pkt_data), .pkt_data_valid(pkt_data_valid), .pkt_data_last(pkt_data_last),
    .pkt_data_ready(rdy_b), .pkt_busy(busy_b), .pkt_done(done_b), .pkt_err(err_b),
    .tx_data(txd_b), .tx_valid(val_b), .tx_ready(tx_ready));

  assign pkt_data_ready = sel ? rdy_b  : rdy_a;
  assign pkt_busy       = sel ? busy_b : busy_a;
  assign pkt_done       = sel ? done_b : done_a;
  assign pkt_err        = sel ? err_b  : err_a;
  assign tx_valid       = sel ? val_b  : val_a;
  assign tx_data        = sel ? txd_b  : txd_a;

  int n_run = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitor: UTMI byte capture, pulse counters, stall stability, source index.
  logic [7:0] capq[$];
  int done_cnt = 0, err_cnt = 0, both_cnt = 0, rdy_cnt = 0, stall_viol = 0, src_idx = 0;
  logic prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;

  always @(posedge clk) begin
    if (rst === 1'b1) begin
      if (tx_valid && tx_ready) capq.push_back(tx_data);
      if (pkt_done) done_cnt <= done_cnt + 1;
      if (pkt_err) err_cnt <= err_cnt + 1;
      if (pkt_done && pkt_err) both_cnt <= both_cnt + 1;
      if (pkt_data_ready) rdy_cnt <= rdy_cnt + 1;
      if (pkt_data_ready && pkt_data_valid) src_idx <= src_idx + 1;
      if (prev_stall && (!tx_valid || tx_data !== prev_data)) stall_viol <= stall_viol + 1;
      prev_stall <= tx_valid && !tx_ready;
      prev_data  <= tx_data;
    end
  end

  // Payload source and UTMI ready generator.
  logic [7:0] pl[$];
  int src_base = 0, src_avail = 0, stall_left = 0;
  logic last_en = 1'b0, stall_en = 1'b0;

  always @(negedge clk) begin
    int k;
    k = src_idx - src_base;
    if (stall_en) begin
      if (stall_left > 0) begin
        tx_ready = 1'b0;
        stall_left--;
      end else begin
        tx_ready = 1'b1;
        stall_left = $urandom_range(0, 7);
      end
    end else begin
      tx_ready = 1'b1;
    end
    pkt_data       = (k >= 0 && k < pl.size()) ? pl[k] : 8'h00;
    pkt_data_valid = (k >= 0 && k < src_avail);
    pkt_data_last  = last_en && (k == pl.size() - 1);
  end

  function automatic logic [15:0] crc16_ref(input logic [7:0] b[$]);
    logic [15:0] c;
    c = 16'hFFFF;
    foreach (b[i]) begin
      c = c ^ {8'h00, b[i]};
      for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic start_pkt(input logic [3:0] pid, input logic zlp, input logic s);
    @(negedge clk);
    sel = s; pkt_pid = pid; pkt_zlp = zlp; pkt_start = 1'b1;
    @(negedge clk);
    pkt_start = 1'b0;
  endtask

  task automatic wait_end(input string tag, input int d0, input int e0);
    int i;
    for (i = 0; i < 400; i++) begin
      if (done_cnt != d0 || err_cnt != e0) break;
      @(negedge clk);
    end
    if (i == 400) chk({tag, "_timeout"}, 32'd1, 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_bytes(input string tag, input int c0, input logic [7:0] exp[$]);
    chk({tag, "_len"}, capq.size() - c0, exp.size());
    foreach (exp[i]) begin
      if (c0 + i < capq.size()) chk($sformatf("%s_b%0d", tag, i), capq[c0 + i], exp[i]);
    end
  endtask

  task automatic run_expect(input string tag, input logic [3:0] pid, input logic zlp, input logic s,
                            input logic [7:0] exp[$], input int exp_done, input int exp_err);
    int c0, d0, e0;
    c0 = capq.size(); d0 = done_cnt; e0 = err_cnt;
    src_base = src_idx;
    start_pkt(pid, zlp, s);
    wait_end(tag, d0, e0);
    check_bytes(tag, c0, exp);
    chk({tag, "_done"}, done_cnt - d0, exp_done);
    chk({tag, "_err"}, err_cnt - e0, exp_err);
    $display("[TB] %s pid=0x%0h: %0d bytes, done=%0d err=%0d", tag, pid, capq.size() - c0,
             done_cnt - d0, err_cnt - e0);
  endtask

  initial begin
    logic [7:0] setup[$];
    logic [7:0] exp4[$];
    logic [7:0] pl4[$];
    logic [15:0] c4;
    int c0, d0, e0, r0;

    setup = '{8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00};
    rst = 1'b0; pkt_start = 1'b0; pkt_pid = 4'h0; pkt_zlp = 1'b0; sel = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_ready", pkt_data_ready, 0);
    chk("rst_busy", pkt_busy, 0);
    chk("rst_done", pkt_done, 0);
    chk("rst_err", pkt_err, 0);
    $display("[TB] reset state checked");
    rst = 1'b1;
    @(negedge clk);

    // ACK with cycle-level timing
    start_pkt(4'h2, 1'b0, 1'b0);
    chk("ack_valid", tx_valid, 1);
    chk("ack_data", tx_data, 8'hD2);
    chk("ack_busy", pkt_busy, 1);
    @(negedge clk);
    chk("ack_done", pkt_done, 1);
    chk("ack_valid_off", tx_valid, 0);
    chk("ack_busy_off", pkt_busy, 0);
    @(negedge clk);
    chk("ack_done_pulse", pkt_done, 0);
    $display("[TB] ack timing checked");

    run_expect("stall", 4'hE, 1'b0, 1'b0, '{8'h1E}, 1, 0);
    run_expect("nak", 4'hA, 1'b0, 1'b0, '{8'h5A}, 1, 0);

    r0 = rdy_cnt;
    run_expect("zlp", 4'hB, 1'b1, 1'b0, '{8'h4B, 8'h00, 8'h00}, 1, 0);
    chk("zlp_no_ready", rdy_cnt - r0, 0);

    pl = setup; src_avail = 8; last_en = 1'b1; stall_en = 1'b1;
    run_expect("data0", 4'h3, 1'b0, 1'b0,
               '{8'hC3, 8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00, 8'hDD, 8'h94}, 1, 0);
    chk("data0_stall_stable", stall_viol, 0);
    stall_en = 1'b0;

    src_avail = 2;
    run_expect("underrun", 4'h3, 1'b0, 1'b0, '{8'hC3, 8'h80, 8'h06}, 0, 1);
    chk("underrun_busy", pkt_busy, 0);
    chk("underrun_valid", tx_valid, 0);

    // IN token rejected
    c0 = capq.size(); e0 = err_cnt;
    start_pkt(4'h9, 1'b0, 1'b0);
    chk("token_err", pkt_err, 1);
    chk("token_valid", tx_valid, 0);
    chk("token_busy", pkt_busy, 0);
    @(negedge clk);
    chk("token_err_pulse", pkt_err, 0);
    chk("token_bytes", capq.size() - c0, 0);
    $display("[TB] token pid=0x9 rejected");

    // pkt_start while busy is ignored
    src_avail = 8; stall_en = 1'b1;
    c0 = capq.size(); d0 = done_cnt; e0 = err_cnt; src_base = src_idx;
    start_pkt(4'h3, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chk("busy_start_inflight", pkt_busy, 1);
    pkt_pid = 4'h2; pkt_start = 1'b1;
    @(negedge clk);
    pkt_start = 1'b0;
    wait_end("busy_start", d0, e0);
    check_bytes("busy_start", c0,
                '{8'hC3, 8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00, 8'hDD, 8'h94});
    chk("busy_start_done", done_cnt - d0, 1);
    chk("busy_start_err", err_cnt - e0, 0);
    $display("[TB] busy start ignored, %0d bytes", capq.size() - c0);
    stall_en = 1'b0;

    // MAX_PAYLOAD=4 truncation, source never asserts last
    pl = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06}; src_avail = 6; last_en = 1'b0;
    pl4 = '{8'h01, 8'h02, 8'h03, 8'h04};
    c4 = crc16_ref(pl4);
    exp4 = '{8'hC3, 8'h01, 8'h02, 8'h03, 8'h04, c4[7:0], c4[15:8]};
    run_expect("max4", 4'h3, 1'b0, 1'b1, exp4, 1, 0);
    sel = 1'b0;

    // Reset in the middle of DATA
    pl = setup; src_avail = 8; last_en = 1'b1;
    d0 = done_cnt; e0 = err_cnt; src_base = src_idx;
    start_pkt(4'h3, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("rst_mid_valid", tx_valid, 0);
    chk("rst_mid_busy", pkt_busy, 0);
    @(negedge clk);
    rst = 1'b1;
    chk("rst_mid_no_pulse", (done_cnt - d0) + (err_cnt - e0), 0);
    $display("[TB] reset mid-DATA, tx_valid=%0d", tx_valid);
    run_expect("ack_after_rst", 4'h2, 1'b0, 1'b0, '{8'hD2}, 1, 0);

    chk("done_err_exclusive", both_cnt, 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
